mc_arbiter: RTL and testbench
=============================

MC_ARBITER -- requirements
Module: mc_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 4: number of requester ports (event cores) sharing one memory controller (MC) port; legal range 2..8.
REQ-002 Parameter MC_RTNCTL_WIDTH, default 32: rtnctl width on the MC side.
REQ-003 Parameter ID_W, default 3: client-ID bits carried in rtnctl bits [MC_RTNCTL_WIDTH-1 -: ID_W]; must satisfy 2^ID_W >= NUM_CLIENTS.
REQ-004 Parameter CL_RTNCTL_WIDTH, default MC_RTNCTL_WIDTH-ID_W: client-side rtnctl width.
REQ-005 The block has one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 cl_rq_vld  in  NUM_CLIENTS  per-client request valid.
REQ-009 cl_rq_cmd/scmd/size  in  3*N / 4*N / 2*N  per-client command, sub-command and size, flattened with client i in slice i.
REQ-010 cl_rq_vadr  in  48*N; cl_rq_data  in  64*N; cl_rq_rtnctl  in  CL_RTNCTL_WIDTH*N.
REQ-011 cl_rq_stall  out  NUM_CLIENTS  per-client back-pressure; the client holds its request while this is asserted.
REQ-012 mc_rq_vld, mc_rq_cmd[2:0], mc_rq_scmd[3:0], mc_rq_vadr[47:0], mc_rq_size[1:0], mc_rq_rtnctl[MC_RTNCTL_WIDTH-1:0], mc_rq_data[63:0], mc_rq_flush  out: MC request port.
REQ-013 mc_rq_stall  in  1  MC back-pressure.
REQ-014 mc_rs_vld, mc_rs_cmd[2:0], mc_rs_scmd[3:0], mc_rs_rtnctl, mc_rs_data[63:0]  in: MC response.
REQ-015 mc_rs_stall  out  1  response back-pressure to the MC.
REQ-016 cl_rs_vld  out  N; cl_rs_cmd  out  3*N; cl_rs_scmd  out  4*N; cl_rs_rtnctl  out  CL_RTNCTL_WIDTH*N; cl_rs_data  out  64*N: per-client responses.
REQ-017 cl_rs_stall  in  NUM_CLIENTS  per-client response back-pressure.

Function
REQ-018 A request transfers to the MC in any cycle with mc_rq_vld=1 and mc_rq_stall=0.
REQ-019 The MC request outputs are driven from a single-entry output register (slot); combinational paths from cl_rq_* to mc_rq_* are not permitted.
REQ-020 The slot is loadable in a cycle when it is empty, or when it is full and transferring that cycle.
REQ-021 Arbitration is round-robin among asserted cl_rq_vld bits, searching from index last_grant+1 with wrap at NUM_CLIENTS-1 to 0.
REQ-022 last_grant updates only when a request is loaded into the slot.
REQ-023 The winner is loaded in a slot-loadable cycle: cl_rq_stall[winner]=0 in that cycle; all other clients see stall=1.
REQ-024 When the slot is not loadable, cl_rq_stall is all ones.
REQ-025 On load, mc_rq_rtnctl = {winner ID (ID_W bits), client rtnctl}, and cmd/scmd/size/vadr/data are copied unchanged.
REQ-026 Latency from acceptance to mc_rq_vld is exactly 1 cycle; sustained throughput is 1 request per cycle when mc_rq_stall=0.
REQ-027 mc_rq_flush is constant 0.
REQ-028 Responses are routed combinationally: id = mc_rs_rtnctl top ID_W bits, cl_rs_vld[id] = mc_rs_vld, other cl_rs_vld bits = 0.
REQ-029 The routed response carries cmd, scmd and data unchanged, with rtnctl = lower CL_RTNCTL_WIDTH bits.
REQ-030 mc_rs_stall = cl_rs_stall[id], independent of the request path.
REQ-031 A response whose id is >= NUM_CLIENTS is dropped: no cl_rs_vld is asserted, mc_rs_stall=0, and the sticky bad_id status bit is set.
REQ-032 Simultaneous events (request accept, MC transfer, response) proceed independently within the same cycle.

Reset
REQ-033 While reset=1, at the next clk edge: the slot is cleared (mc_rq_vld=0, all mc_rq_* data fields 0), last_grant = NUM_CLIENTS-1 (client 0 is first priority), and bad_id is cleared.
REQ-034 While reset=1, cl_rq_stall is all ones.
REQ-035 Reset asserted mid-operation discards any pending slot contents; no request is issued after reset.

Verification
REQ-036 After reset, all 4 clients assert valid continuously with mc_rq_stall=0 -> grants in order 0,1,2,3,0; rtnctl top 3 bits are 0,1,2,3,0 on consecutive cycles.
REQ-037 Client 2 requests vadr=0x100 and mc_rq_stall=1 for 5 cycles -> mc_rq_vld is held with vadr=0x100 throughout, all cl_rq_stall=1, and the transfer occurs on the first cycle with stall=0.
REQ-038 mc_rs_vld with rtnctl id=3, low bits 0x55, and cl_rs_stall[3]=1 -> cl_rs_vld[3]=1, cl_rs_rtnctl=0x55, mc_rs_stall=1; when stall clears, mc_rs_stall=0.
REQ-039 Response with id=6 -> no cl_rs_vld asserted and bad_id=1.
REQ-040 Reset asserted while the slot is full and stalled -> mc_rq_vld=0 on the next cycle; after release, client 0 wins first.
REQ-041 Integrate 4 phold-style clients with dummy_mc (RAM_DEPTH 128) -> every issued read returns to the client matching its original client rtnctl, with no loss or duplication over 1000 requests.

Source files
------------

// File: rtl/mc_arbiter.sv
// -----------------------------------------------------------------------------
// mc_arbiter
//
// Shares one memory-controller (MC) request/response port among NUM_CLIENTS
// requesters.
//
// Request path:
//   - Round-robin arbitration across the asserted cl_rq_vld bits.
//   - The winner is captured into a single-entry output slot, which drives
//     mc_rq_*. There is no combinational path from cl_rq_* to mc_rq_*.
//   - The winner's ID is prepended to its rtnctl so that the response can be
//     routed back to the right client.
//
// Response path:
//   - Purely combinational.
//   - The top ID_W bits of mc_rs_rtnctl select the destination client.
//   - The lower CL_RTNCTL_WIDTH bits are handed back to that client.
//   - A response with an out-of-range ID is dropped and sets the sticky
//     bad_id bit.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cl_rq_*               flattened per-client request inputs (client i in slice i)
//   cl_rq_stall           per-client request back-pressure
//   mc_rq_*               MC request port (registered)
//   mc_rq_stall           MC request back-pressure
//   mc_rs_*               MC response inputs
//   mc_rs_stall           response back-pressure to the MC
//   cl_rs_*               per-client response outputs
//   cl_rs_stall           per-client response back-pressure
//   bad_id                sticky: a response arrived with an ID >= NUM_CLIENTS
// -----------------------------------------------------------------------------
module mc_arbiter #(
  parameter int NUM_CLIENTS     = 4,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int ID_W            = 3,
  parameter int CL_RTNCTL_WIDTH = MC_RTNCTL_WIDTH - ID_W
) (
  input  logic                                   clk,
  input  logic                                   reset,

  input  logic [NUM_CLIENTS-1:0]                 cl_rq_vld,
  input  logic [3*NUM_CLIENTS-1:0]               cl_rq_cmd,
  input  logic [4*NUM_CLIENTS-1:0]               cl_rq_scmd,
  input  logic [2*NUM_CLIENTS-1:0]               cl_rq_size,
  input  logic [48*NUM_CLIENTS-1:0]              cl_rq_vadr,
  input  logic [64*NUM_CLIENTS-1:0]              cl_rq_data,
  input  logic [CL_RTNCTL_WIDTH*NUM_CLIENTS-1:0] cl_rq_rtnctl,
  output logic [NUM_CLIENTS-1:0]                 cl_rq_stall,

  output logic                                   mc_rq_vld,
  output logic [2:0]                             mc_rq_cmd,
  output logic [3:0]                             mc_rq_scmd,
  output logic [47:0]                            mc_rq_vadr,
  output logic [1:0]                             mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0]             mc_rq_rtnctl,
  output logic [63:0]                            mc_rq_data,
  output logic                                   mc_rq_flush,
  input  logic                                   mc_rq_stall,

  input  logic                                   mc_rs_vld,
  input  logic [2:0]                             mc_rs_cmd,
  input  logic [3:0]                             mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]             mc_rs_rtnctl,
  input  logic [63:0]                            mc_rs_data,
  output logic                                   mc_rs_stall,

  output logic [NUM_CLIENTS-1:0]                 cl_rs_vld,
  output logic [3*NUM_CLIENTS-1:0]               cl_rs_cmd,
  output logic [4*NUM_CLIENTS-1:0]               cl_rs_scmd,
  output logic [CL_RTNCTL_WIDTH*NUM_CLIENTS-1:0] cl_rs_rtnctl,
  output logic [64*NUM_CLIENTS-1:0]              cl_rs_data,
  input  logic [NUM_CLIENTS-1:0]                 cl_rs_stall,

  output logic                                   bad_id
);

  localparam int              LG_W   = $clog2(NUM_CLIENTS);
  localparam logic [LG_W:0]   NC_LG  = (LG_W+1)'(NUM_CLIENTS);
  localparam logic [ID_W:0]   NC_ID  = (ID_W+1)'(NUM_CLIENTS);
  localparam logic [LG_W-1:0] LAST_C = LG_W'(NUM_CLIENTS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                       slot_vld_q,    slot_vld_d;
  logic [2:0]                 slot_cmd_q,    slot_cmd_d;
  logic [3:0]                 slot_scmd_q,   slot_scmd_d;
  logic [1:0]                 slot_size_q,   slot_size_d;
  logic [47:0]                slot_vadr_q,   slot_vadr_d;
  logic [63:0]                slot_data_q,   slot_data_d;
  logic [MC_RTNCTL_WIDTH-1:0] slot_rtnctl_q, slot_rtnctl_d;
  logic [LG_W-1:0]            last_grant_q,  last_grant_d;
  logic                       bad_id_q,      bad_id_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                       slot_load_ok;
  logic                       grant_found;
  logic [LG_W-1:0]            grant_idx;
  logic [LG_W:0]              cand;
  logic                       accept;

  // Winner's request fields, selected from the flattened inputs
  logic [2:0]                 sel_cmd;
  logic [3:0]                 sel_scmd;
  logic [1:0]                 sel_size;
  logic [47:0]                sel_vadr;
  logic [63:0]                sel_data;
  logic [CL_RTNCTL_WIDTH-1:0] sel_rtnctl;

  // The slot can take a new entry if it is empty, or if its current
  // occupant leaves for the MC in this same cycle.
  assign slot_load_ok = !slot_vld_q || !mc_rq_stall;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    // Scan from last_grant+1 upward. The candidate index wraps back to 0
    // after NUM_CLIENTS-1.
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = {1'b0, last_grant_q} + (LG_W+1)'(k);
      if (cand >= NC_LG) begin
        cand = cand - NC_LG;
      end
      if (!grant_found && cl_rq_vld[cand[LG_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[LG_W-1:0];
      end
    end
  end

  assign accept = slot_load_ok && grant_found && !reset;

  always_comb begin
    cl_rq_stall = '1;
    if (accept) begin
      cl_rq_stall[grant_idx] = 1'b0;
    end
  end

  always_comb begin
    sel_cmd    = '0;
    sel_scmd   = '0;
    sel_size   = '0;
    sel_vadr   = '0;
    sel_data   = '0;
    sel_rtnctl = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_idx == LG_W'(i)) begin
        sel_cmd    = cl_rq_cmd[i*3 +: 3];
        sel_scmd   = cl_rq_scmd[i*4 +: 4];
        sel_size   = cl_rq_size[i*2 +: 2];
        sel_vadr   = cl_rq_vadr[i*48 +: 48];
        sel_data   = cl_rq_data[i*64 +: 64];
        sel_rtnctl = cl_rq_rtnctl[i*CL_RTNCTL_WIDTH +: CL_RTNCTL_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] rs_id;
  logic            rs_id_ok;

  assign rs_id    = mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: ID_W];
  assign rs_id_ok = ({1'b0, rs_id} < NC_ID);

  // Only IDs of existing clients have a match in this loop. An out-of-range
  // ID therefore raises no valid, and mc_rs_stall stays low, so the MC
  // drains the stray response.
  always_comb begin
    cl_rs_vld   = '0;
    mc_rs_stall = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (rs_id == ID_W'(i)) begin
        cl_rs_vld[i] = mc_rs_vld;
        mc_rs_stall  = cl_rs_stall[i];
      end
    end
  end

  // Payload is broadcast to every client; only the client with cl_rs_vld
  // set consumes it.
  assign cl_rs_cmd    = {NUM_CLIENTS{mc_rs_cmd}};
  assign cl_rs_scmd   = {NUM_CLIENTS{mc_rs_scmd}};
  assign cl_rs_data   = {NUM_CLIENTS{mc_rs_data}};
  assign cl_rs_rtnctl = {NUM_CLIENTS{mc_rs_rtnctl[CL_RTNCTL_WIDTH-1:0]}};

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_vld_d    = slot_vld_q;
    slot_cmd_d    = slot_cmd_q;
    slot_scmd_d   = slot_scmd_q;
    slot_size_d   = slot_size_q;
    slot_vadr_d   = slot_vadr_q;
    slot_data_d   = slot_data_q;
    slot_rtnctl_d = slot_rtnctl_q;
    last_grant_d  = last_grant_q;
    bad_id_d      = bad_id_q | (mc_rs_vld & ~rs_id_ok);

    if (accept) begin
      slot_vld_d    = 1'b1;
      slot_cmd_d    = sel_cmd;
      slot_scmd_d   = sel_scmd;
      slot_size_d   = sel_size;
      slot_vadr_d   = sel_vadr;
      slot_data_d   = sel_data;
      slot_rtnctl_d = {ID_W'(grant_idx), sel_rtnctl};
      last_grant_d  = grant_idx;
    end else if (slot_vld_q && !mc_rq_stall) begin
      slot_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld_q    <= 1'b0;
      slot_cmd_q    <= '0;
      slot_scmd_q   <= '0;
      slot_size_q   <= '0;
      slot_vadr_q   <= '0;
      slot_data_q   <= '0;
      slot_rtnctl_q <= '0;
      last_grant_q  <= LAST_C;
      bad_id_q      <= 1'b0;
    end else begin
      slot_vld_q    <= slot_vld_d;
      slot_cmd_q    <= slot_cmd_d;
      slot_scmd_q   <= slot_scmd_d;
      slot_size_q   <= slot_size_d;
      slot_vadr_q   <= slot_vadr_d;
      slot_data_q   <= slot_data_d;
      slot_rtnctl_q <= slot_rtnctl_d;
      last_grant_q  <= last_grant_d;
      bad_id_q      <= bad_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mc_rq_vld    = slot_vld_q;
  assign mc_rq_cmd    = slot_cmd_q;
  assign mc_rq_scmd   = slot_scmd_q;
  assign mc_rq_size   = slot_size_q;
  assign mc_rq_vadr   = slot_vadr_q;
  assign mc_rq_data   = slot_data_q;
  assign mc_rq_rtnctl = slot_rtnctl_q;
  assign mc_rq_flush  = 1'b0;
  assign bad_id       = bad_id_q;

endmodule

// File: tb/tb_mc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mc_arbiter
//
// Directed scenarios, followed by a randomized traffic phase.
//
// In the random phase, four clients hold their requests while stalled. A
// simple in-order MC model echoes every transferred request back as a
// response. Every DUT output is compared each cycle against a behavioural
// model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mc_arbiter;
  localparam int N    = 4;
  localparam int MCW  = 32;
  localparam int IDW  = 3;
  localparam int CLW  = MCW - IDW;
  localparam int NREQ = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic               reset;
  logic [N-1:0]       cl_rq_vld;
  logic [3*N-1:0]     cl_rq_cmd;
  logic [4*N-1:0]     cl_rq_scmd;
  logic [2*N-1:0]     cl_rq_size;
  logic [48*N-1:0]    cl_rq_vadr;
  logic [64*N-1:0]    cl_rq_data;
  logic [CLW*N-1:0]   cl_rq_rtnctl;
  logic [N-1:0]       cl_rq_stall;

  logic               mc_rq_vld;
  logic [2:0]         mc_rq_cmd;
  logic [3:0]         mc_rq_scmd;
  logic [47:0]        mc_rq_vadr;
  logic [1:0]         mc_rq_size;
  logic [MCW-1:0]     mc_rq_rtnctl;
  logic [63:0]        mc_rq_data;
  logic               mc_rq_flush;
  logic               mc_rq_stall;

  logic               mc_rs_vld;
  logic [2:0]         mc_rs_cmd;
  logic [3:0]         mc_rs_scmd;
  logic [MCW-1:0]     mc_rs_rtnctl;
  logic [63:0]        mc_rs_data;
  logic               mc_rs_stall;

  logic [N-1:0]       cl_rs_vld;
  logic [3*N-1:0]     cl_rs_cmd;
  logic [4*N-1:0]     cl_rs_scmd;
  logic [CLW*N-1:0]   cl_rs_rtnctl;
  logic [64*N-1:0]    cl_rs_data;
  logic [N-1:0]       cl_rs_stall;
  logic               bad_id;

  mc_arbiter #(
    .NUM_CLIENTS(N),
    .MC_RTNCTL_WIDTH(MCW),
    .ID_W(IDW),
    .CL_RTNCTL_WIDTH(CLW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cl_rq_vld(cl_rq_vld),
    .cl_rq_cmd(cl_rq_cmd),
    .cl_rq_scmd(cl_rq_scmd),
    .cl_rq_size(cl_rq_size),
    .cl_rq_vadr(cl_rq_vadr),
    .cl_rq_data(cl_rq_data),
    .cl_rq_rtnctl(cl_rq_rtnctl),
    .cl_rq_stall(cl_rq_stall),
    .mc_rq_vld(mc_rq_vld),
    .mc_rq_cmd(mc_rq_cmd),
    .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr),
    .mc_rq_size(mc_rq_size),
    .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data),
    .mc_rq_flush(mc_rq_flush),
    .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld),
    .mc_rs_cmd(mc_rs_cmd),
    .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl),
    .mc_rs_data(mc_rs_data),
    .mc_rs_stall(mc_rs_stall),
    .cl_rs_vld(cl_rs_vld),
    .cl_rs_cmd(cl_rs_cmd),
    .cl_rs_scmd(cl_rs_scmd),
    .cl_rs_rtnctl(cl_rs_rtnctl),
    .cl_rs_data(cl_rs_data),
    .cl_rs_stall(cl_rs_stall),
    .bad_id(bad_id)
  );

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Client-side request state (unflattened)
  // ---------------------------------------------------------------------------
  logic [N-1:0]   rq_vld;
  logic [2:0]     rq_cmd  [N];
  logic [3:0]     rq_scmd [N];
  logic [1:0]     rq_size [N];
  logic [47:0]    rq_vadr [N];
  logic [63:0]    rq_data [N];
  logic [CLW-1:0] rq_rt   [N];

  // ---------------------------------------------------------------------------
  // Reference model: output slot contents, last winner, sticky bad-id flag
  // ---------------------------------------------------------------------------
  int             m_last = N - 1;
  bit             m_v    = 1'b0;
  bit             m_bad  = 1'b0;
  logic [2:0]     m_cmd  = '0;
  logic [3:0]     m_scmd = '0;
  logic [1:0]     m_size = '0;
  logic [47:0]    m_vadr = '0;
  logic [63:0]    m_data = '0;
  logic [MCW-1:0] m_rt   = '0;

  // ---------------------------------------------------------------------------
  // Per-cycle events observed by step(), consumed by the stimulus code
  // ---------------------------------------------------------------------------
  int             g_win;
  bit             g_xfer;
  logic [MCW-1:0] g_xfer_rt;
  bit             g_rs_take;
  bit             g_cl_take [N];
  logic [CLW-1:0] g_cl_rt   [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    cl_rq_vld = rq_vld;
    for (int i = 0; i < N; i++) begin
      cl_rq_cmd[i*3 +: 3]      = rq_cmd[i];
      cl_rq_scmd[i*4 +: 4]     = rq_scmd[i];
      cl_rq_size[i*2 +: 2]     = rq_size[i];
      cl_rq_vadr[i*48 +: 48]   = rq_vadr[i];
      cl_rq_data[i*64 +: 64]   = rq_data[i];
      cl_rq_rtnctl[i*CLW +: CLW] = rq_rt[i];
    end
  endtask

  // Apply the current inputs for one clock cycle:
  //   1. At the falling edge, check every DUT output against the model.
  //   2. At the rising edge, advance the model.
  //   3. Return 1 time unit after the rising edge.
  task automatic step();
    logic [N-1:0] exp_stall;
    logic [N-1:0] exp_rs_vld;
    bit           exp_mrs;
    int           id;

    pack();
    @(negedge clk);

    // Round-robin winner: first valid client after the last winner, wrapping.
    g_win = -1;
    if (!reset && (!m_v || !mc_rq_stall)) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (g_win < 0 && rq_vld[c]) g_win = c;
      end
    end

    exp_stall = '1;
    if (g_win >= 0) exp_stall[g_win] = 1'b0;
    chk("rq_stall",  cl_rq_stall, exp_stall);
    chk("mc_rq_vld", mc_rq_vld,   m_v);
    chk("rq_flush",  mc_rq_flush, 1'b0);
    chk("bad_id",    bad_id,      m_bad);

    if (m_v) begin
      chk("rq_cmd",    mc_rq_cmd,    m_cmd);
      chk("rq_scmd",   mc_rq_scmd,   m_scmd);
      chk("rq_size",   mc_rq_size,   m_size);
      chk("rq_vadr",   mc_rq_vadr,   m_vadr);
      chk("rq_data",   mc_rq_data,   m_data);
      chk("rq_rtnctl", mc_rq_rtnctl, m_rt);
    end

    id         = int'(mc_rs_rtnctl[MCW-1 -: IDW]);
    exp_rs_vld = '0;
    exp_mrs    = 1'b0;
    if (id < N) begin
      exp_rs_vld[id] = mc_rs_vld;
      exp_mrs        = cl_rs_stall[id];
    end
    chk("cl_rs_vld",   cl_rs_vld,   exp_rs_vld);
    chk("mc_rs_stall", mc_rs_stall, exp_mrs);

    if (id < N && mc_rs_vld) begin
      chk("rs_rtnctl", cl_rs_rtnctl[id*CLW +: CLW], mc_rs_rtnctl[CLW-1:0]);
      chk("rs_data",   cl_rs_data[id*64 +: 64],     mc_rs_data);
      chk("rs_cmd",    cl_rs_cmd[id*3 +: 3],        mc_rs_cmd);
      chk("rs_scmd",   cl_rs_scmd[id*4 +: 4],       mc_rs_scmd);
    end

    g_xfer    = m_v && !mc_rq_stall;
    g_xfer_rt = m_rt;
    g_rs_take = mc_rs_vld && !exp_mrs;
    for (int i = 0; i < N; i++) begin
      g_cl_take[i] = (cl_rs_vld[i] === 1'b1) && !cl_rs_stall[i];
      g_cl_rt[i]   = cl_rs_rtnctl[i*CLW +: CLW];
    end

    @(posedge clk);
    if (reset) begin
      m_v    = 1'b0;
      m_cmd  = '0;
      m_scmd = '0;
      m_size = '0;
      m_vadr = '0;
      m_data = '0;
      m_rt   = '0;
      m_last = N - 1;
      m_bad  = 1'b0;
    end else begin
      if (mc_rs_vld && id >= N) m_bad = 1'b1;
      if (g_win >= 0) begin
        m_v    = 1'b1;
        m_cmd  = rq_cmd[g_win];
        m_scmd = rq_scmd[g_win];
        m_size = rq_size[g_win];
        m_vadr = rq_vadr[g_win];
        m_data = rq_data[g_win];
        m_rt   = {3'(g_win), rq_rt[g_win]};
        m_last = g_win;
      end else if (m_v && !mc_rq_stall) begin
        m_v = 1'b0;
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Random-phase scoreboard
  // ---------------------------------------------------------------------------
  logic [CLW-1:0] outst [N][$];
  logic [MCW-1:0] mcq[$];
  int             seqn [N];

  function automatic int n_outst();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += outst[i].size();
    return s;
  endfunction

  initial begin
    int  issued;
    int  received;
    int  cyc;
    bit  rs_busy;

    reset        = 1'b1;
    rq_vld       = '0;
    mc_rq_stall  = 1'b0;
    mc_rs_vld    = 1'b0;
    mc_rs_cmd    = '0;
    mc_rs_scmd   = '0;
    mc_rs_rtnctl = '0;
    mc_rs_data   = '0;
    cl_rs_stall  = '0;
    for (int i = 0; i < N; i++) begin
      rq_cmd[i]  = 3'(i + 1);
      rq_scmd[i] = 4'(i + 8);
      rq_size[i] = 2'(i);
      rq_vadr[i] = 48'h1000 * 48'(i + 1);
      rq_data[i] = 64'hA000_0000_0000_0000 + 64'(i);
      rq_rt[i]   = 29'(32'h10 + 32'(i));
      seqn[i]    = 0;
    end
    pack();
    repeat (2) @(posedge clk);
    #1;

    // ---- Reset behaviour: every client requests, yet all stay stalled ----
    rq_vld = '1;
    step();
    chk("rst_vadr",   mc_rq_vadr,   48'h0);
    chk("rst_data",   mc_rq_data,   64'h0);
    chk("rst_rtnctl", mc_rq_rtnctl, 32'h0);

    // ---- Round-robin with all four clients requesting continuously ----
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("rr_vld", mc_rq_vld,          1'b1);
      chk("rr_seq", mc_rq_rtnctl[31:29], 3'(j % 4));
    end

    // ---- Slot held under MC stall ----
    rq_vld = '0;
    step();
    chk("drained", mc_rq_vld, 1'b0);

    rq_vld     = 4'b0100;
    rq_vadr[2] = 48'h100;
    step();

    rq_vld      = 4'b0011;
    mc_rq_stall = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("hold_vld",   mc_rq_vld,   1'b1);
      chk("hold_vadr",  mc_rq_vadr,  48'h100);
      chk("hold_stall", cl_rq_stall, 4'hF);
    end

    mc_rq_stall = 1'b0;
    rq_vld      = '0;
    step();
    chk("xfer_fire",  g_xfer,           1'b1);
    chk("xfer_id",    g_xfer_rt[31:29], 3'd2);
    chk("xfer_empty", mc_rq_vld,        1'b0);

    // ---- Response routing with client back-pressure ----
    mc_rs_vld    = 1'b1;
    mc_rs_rtnctl = {3'd3, 29'h55};
    mc_rs_data   = 64'hDEAD_BEEF_0123_4567;
    mc_rs_cmd    = 3'd2;
    mc_rs_scmd   = 4'd5;
    cl_rs_stall  = 4'b1000;
    step();
    chk("rs3_vld",      cl_rs_vld,                     4'b1000);
    chk("rs3_rtnctl",   cl_rs_rtnctl[3*CLW +: CLW],    29'h55);
    chk("rs3_stall_up", mc_rs_stall,                   1'b1);

    cl_rs_stall = '0;
    #1;
    chk("rs3_stall_dn", mc_rs_stall, 1'b0);
    step();

    // ---- Out-of-range response IDs ----
    mc_rs_rtnctl = {3'd4, 29'h12};
    cl_rs_stall  = '1;
    step();
    chk("id4_vld",   cl_rs_vld,   4'b0000);
    chk("id4_stall", mc_rs_stall, 1'b0);

    mc_rs_rtnctl = {3'd6, 29'h77};
    cl_rs_stall  = '0;
    step();
    chk("id6_vld", cl_rs_vld, 4'b0000);
    chk("id6_bad", bad_id,    1'b1);

    mc_rs_vld    = 1'b0;
    mc_rs_rtnctl = '0;
    step();
    chk("bad_sticky", bad_id, 1'b1);

    // ---- Reset while the slot is full and stalled ----
    rq_vld      = 4'b0010;
    mc_rq_stall = 1'b1;
    step();
    rq_vld = '0;
    step();
    chk("pre_rst_full", mc_rq_vld, 1'b1);

    reset = 1'b1;
    step();
    chk("rst_drop",    mc_rq_vld, 1'b0);
    chk("rst_bad_clr", bad_id,    1'b0);

    reset       = 1'b0;
    mc_rq_stall = 1'b0;
    rq_vld      = '1;
    step();
    chk("post_rst_first", mc_rq_rtnctl[31:29], 3'd0);

    rq_vld = '0;
    step();

    // ---- Randomized traffic against an in-order MC model ----
    issued   = 0;
    received = 0;
    cyc      = 0;
    rs_busy  = 1'b0;
    while ((issued < NREQ || n_outst() > 0 || mcq.size() > 0 || rs_busy) && cyc < 30000) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_vld[i] && issued < NREQ && $urandom_range(9) < 6) begin
          rq_vld[i]  = 1'b1;
          rq_cmd[i]  = 3'($urandom);
          rq_scmd[i] = 4'($urandom);
          rq_size[i] = 2'($urandom);
          rq_vadr[i] = {16'($urandom), 32'($urandom)};
          rq_data[i] = {32'($urandom), 32'($urandom)};
          rq_rt[i]   = {8'(i), 21'(seqn[i])};
          seqn[i]++;
          issued++;
        end
      end

      mc_rq_stall = ($urandom_range(3) == 0);

      if (!rs_busy && mcq.size() > 0 && $urandom_range(3) != 0) begin
        rs_busy      = 1'b1;
        mc_rs_vld    = 1'b1;
        mc_rs_rtnctl = mcq[0];
        mc_rs_data   = {mcq[0], 32'h5A5A_0F0F};
        mc_rs_cmd    = 3'($urandom);
        mc_rs_scmd   = 4'($urandom);
      end

      cl_rs_stall = 4'($urandom) & 4'($urandom);

      step();
      cyc++;

      if (g_win >= 0) begin
        outst[g_win].push_back(rq_rt[g_win]);
        rq_vld[g_win] = 1'b0;
      end

      if (g_xfer) mcq.push_back(g_xfer_rt);

      if (rs_busy && g_rs_take) begin
        void'(mcq.pop_front());
        rs_busy   = 1'b0;
        mc_rs_vld = 1'b0;
      end

      for (int i = 0; i < N; i++) begin
        if (g_cl_take[i]) begin
          received++;
          chk("rs_expected", 64'(outst[i].size() > 0), 64'd1);
          if (outst[i].size() > 0) begin
            chk("rs_order", g_cl_rt[i], outst[i][0]);
            void'(outst[i].pop_front());
          end
        end
      end
    end

    chk("rand_issued",   issued,    NREQ);
    chk("rand_received", received,  NREQ);
    chk("rand_outst",    n_outst(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
